// File: rtl/vga_fb_scanout.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_scanout
// Brief    : VGA timing and 4x-upscaled scan-out of an RGB565 framebuffer.
// Revision : 1.0
// ============================================================================
module vga_fb_scanout #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int FB_WIDTH   = 160,
   parameter int FB_HEIGHT  = 120,
   parameter int SCALE_LOG2 = 2,
   parameter int ADDR_W     = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic [ADDR_W-1:0] mem_address,
   input  logic [15:0]       mem_readdata,
   output logic [7:0]        vga_r,
   output logic [7:0]        vga_g,
   output logic [7:0]        vga_b,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              vga_blank_n,
   output logic              frame_start
);

   localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int c_HW      = $clog2(c_H_TOTAL);
   localparam int c_VW      = $clog2(c_V_TOTAL);

   localparam logic [c_HW-1:0]   c_H_LAST    = c_HW'(c_H_TOTAL - 1);
   localparam logic [c_VW-1:0]   c_V_LAST    = c_VW'(c_V_TOTAL - 1);
   localparam logic [c_HW-1:0]   c_H_ACT     = c_HW'(H_ACTIVE);
   localparam logic [c_VW-1:0]   c_V_ACT     = c_VW'(V_ACTIVE);
   localparam logic [c_HW-1:0]   c_HS_START  = c_HW'(H_ACTIVE + H_FP);
   localparam logic [c_HW-1:0]   c_HS_END    = c_HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [c_VW-1:0]   c_VS_START  = c_VW'(V_ACTIVE + V_FP);
   localparam logic [c_VW-1:0]   c_VS_END    = c_VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [ADDR_W-1:0] c_FB_STRIDE = ADDR_W'(FB_WIDTH);

   if (((FB_WIDTH << SCALE_LOG2) != H_ACTIVE) ||
       ((FB_HEIGHT << SCALE_LOG2) != V_ACTIVE)) begin : g_geom_check
      $error("framebuffer size does not upscale to the active area");
   end

   logic [c_HW-1:0]   r_h_cnt;
   logic [c_VW-1:0]   r_v_cnt;
   logic [ADDR_W-1:0] r_line_base;
   logic [1:0]        r_act_d;
   logic [1:0]        r_hs_n_d;
   logic [1:0]        r_vs_n_d;
   logic [1:0]        r_fs_d;

   logic              w_h_wrap;
   logic              w_v_wrap;
   logic              w_active;
   logic              w_hs_n;
   logic              w_vs_n;
   logic              w_fs;
   logic [ADDR_W-1:0] w_addr;

   assign w_h_wrap = (r_h_cnt == c_H_LAST);
   assign w_v_wrap = (r_v_cnt == c_V_LAST);
   assign w_active = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
   assign w_hs_n   = !((r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END));
   assign w_vs_n   = !((r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END));
   assign w_fs     = (r_h_cnt == '0) && (r_v_cnt == '0);
   assign w_addr   = r_line_base + ADDR_W'(r_h_cnt >> SCALE_LOG2);

   // line_base advances after the last of the SCALE repeats of each source line
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_h_cnt     <= '0;
         r_v_cnt     <= '0;
         r_line_base <= '0;
      end else if (w_h_wrap) begin
         r_h_cnt <= '0;
         if (w_v_wrap) begin
            r_v_cnt     <= '0;
            r_line_base <= '0;
         end else begin
            r_v_cnt <= r_v_cnt + c_VW'(1);
            if (&r_v_cnt[SCALE_LOG2-1:0]) begin
               r_line_base <= r_line_base + c_FB_STRIDE;
            end
         end
      end else begin
         r_h_cnt <= r_h_cnt + c_HW'(1);
      end
   end

   // Stage 1 issues the address, stage 2 waits for RAM q, stage 3 drives the pins
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_address <= '0;
         r_act_d     <= '0;
         r_hs_n_d    <= '1;
         r_vs_n_d    <= '1;
         r_fs_d      <= '0;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         vga_blank_n <= 1'b0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         mem_address <= w_active ? w_addr : '0;
         r_act_d     <= {r_act_d[0], w_active};
         r_hs_n_d    <= {r_hs_n_d[0], w_hs_n};
         r_vs_n_d    <= {r_vs_n_d[0], w_vs_n};
         r_fs_d      <= {r_fs_d[0], w_fs};
         vga_blank_n <= r_act_d[1];
         vga_hs      <= r_hs_n_d[1];
         vga_vs      <= r_vs_n_d[1];
         frame_start <= r_fs_d[1];
         if (r_act_d[1]) begin
            vga_r <= {mem_readdata[15:11], mem_readdata[15:13]};
            vga_g <= {mem_readdata[10:5],  mem_readdata[10:9]};
            vga_b <= {mem_readdata[4:0],   mem_readdata[4:2]};
         end else begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
         end
      end
   end

endmodule
`default_nettype wire
